// File: rtl/axis_frame_gen_if.sv
// AXI-stream video channel used by the frame generator.
// Signal names match the generator's stream ports.
interface axis_frame_gen_if;
    logic        aclk_tready;
    logic        aclk_tvalid;
    logic [63:0] aclk_tdata;
    logic [3:0]  aclk_tuser;
    logic        aclk_tlast;

    modport master (
        input  aclk_tready,
        output aclk_tvalid,
        output aclk_tdata,
        output aclk_tuser,
        output aclk_tlast
    );

    modport slave (
        output aclk_tready,
        input  aclk_tvalid,
        input  aclk_tdata,
        input  aclk_tuser,
        input  aclk_tlast
    );
endinterface

// File: rtl/axis_frame_gen.sv
// Test-pattern frame generator: emits x_size by y_size frames as 64-bit AXI-stream
// beats with SOF/SOL/EOL/EOF flags in tuser and optional idle gaps between lines.
module axis_frame_gen #(
    parameter int PATTERN = 0
) (
    input  logic               aclk,
    input  logic               aclk_reset_n,
    input  logic               aclk_start,
    input  logic [2:0]         aclk_color_space,
    input  logic [12:0]        aclk_x_size,
    input  logic [12:0]        aclk_y_size,
    input  logic [15:0]        aclk_line_gap,
    output logic               aclk_busy,
    output logic               aclk_frame_done,
    axis_frame_gen_if.master   m_axis
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [2:0]  r_color_space;
    logic [12:0] r_x_size;
    logic [12:0] r_y_size;
    logic [15:0] r_line_gap;
    logic [15:0] r_beat;
    logic [15:0] r_line;
    logic [15:0] r_gap_cnt;
    logic [15:0] r_byte_base;
    logic        r_frame_done;

    logic        w_pw4;
    logic [15:0] w_line_bytes;
    logic [15:0] w_beats_per_line;
    logic        w_valid;
    logic        w_xfer;
    logic        w_first_beat;
    logic        w_last_beat;
    logic        w_final_line;
    logic        w_start_ok;
    logic        w_start_empty;

    // Line geometry is derived from the latched config; 8191*4 bytes still fits 16 bits.
    assign w_pw4            = (r_color_space == 3'd1) || (r_color_space == 3'd2) ||
                              (r_color_space == 3'd5);
    assign w_line_bytes     = w_pw4 ? {1'b0, r_x_size, 2'b00} : {3'b000, r_x_size};
    assign w_beats_per_line = {3'b000, w_line_bytes[15:3]} + {15'd0, |w_line_bytes[2:0]};

    assign w_valid       = (r_state == DATA);
    assign w_xfer        = w_valid && m_axis.aclk_tready;
    assign w_first_beat  = (r_beat == 16'd0);
    assign w_last_beat   = (r_beat == (w_beats_per_line - 16'd1));
    assign w_final_line  = (r_line == ({3'b000, r_y_size} - 16'd1));
    assign w_start_ok    = (r_state == IDLE) && aclk_start &&
                           (aclk_x_size != 13'd0) && (aclk_y_size != 13'd0);
    assign w_start_empty = (r_state == IDLE) && aclk_start &&
                           ((aclk_x_size == 13'd0) || (aclk_y_size == 13'd0));

    always_ff @(posedge aclk) begin
        if (!aclk_reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_start_ok) begin
                    w_state_next = DATA;
                end
            end
            DATA: begin
                if (w_xfer && w_last_beat) begin
                    if (w_final_line) begin
                        w_state_next = IDLE;
                    end else if (r_line_gap != 16'd0) begin
                        w_state_next = GAP;
                    end
                end
            end
            GAP: begin
                if (r_gap_cnt == (r_line_gap - 16'd1)) begin
                    w_state_next = DATA;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aclk_reset_n) begin
            r_color_space <= 3'd0;
            r_x_size      <= 13'd0;
            r_y_size      <= 13'd0;
            r_line_gap    <= 16'd0;
            r_beat        <= 16'd0;
            r_line        <= 16'd0;
            r_gap_cnt     <= 16'd0;
            r_byte_base   <= 16'd0;
            r_frame_done  <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start_ok) begin
                        r_color_space <= aclk_color_space;
                        r_x_size      <= aclk_x_size;
                        r_y_size      <= aclk_y_size;
                        r_line_gap    <= aclk_line_gap;
                        r_beat        <= 16'd0;
                        r_line        <= 16'd0;
                        r_gap_cnt     <= 16'd0;
                        r_byte_base   <= 16'd0;
                    end else if (w_start_empty) begin
                        r_frame_done <= 1'b1;
                    end
                end
                DATA: begin
                    if (w_xfer) begin
                        if (w_last_beat) begin
                            r_beat      <= 16'd0;
                            r_byte_base <= 16'd0;
                            r_gap_cnt   <= 16'd0;
                            if (w_final_line) begin
                                r_line       <= 16'd0;
                                r_frame_done <= 1'b1;
                            end else begin
                                r_line <= r_line + 16'd1;
                            end
                        end else begin
                            r_beat      <= r_beat + 16'd1;
                            r_byte_base <= r_byte_base + 16'd8;
                        end
                    end
                end
                GAP: begin
                    r_gap_cnt <= r_gap_cnt + 16'd1;
                end
                default: ;
            endcase
        end
    end

    // Byte lanes: lane gi carries line byte (base + gi); bytes beyond the line are zero.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_lane
            logic [15:0] w_k;
            logic [7:0]  w_pix;
            logic [7:0]  w_val;
            assign w_k   = r_byte_base + 16'(gi);
            assign w_pix = w_pw4 ? w_k[9:2] : w_k[7:0];
            assign w_val = (PATTERN == 1) ? (w_pix + r_line[7:0]) : w_pix;
            assign m_axis.aclk_tdata[gi*8 +: 8] =
                (w_valid && (w_k < w_line_bytes)) ? w_val : 8'd0;
        end
    endgenerate

    assign m_axis.aclk_tvalid   = w_valid;
    assign m_axis.aclk_tlast    = w_valid && w_last_beat;
    assign m_axis.aclk_tuser[0] = w_valid && w_first_beat && (r_line == 16'd0);
    assign m_axis.aclk_tuser[1] = w_valid && w_last_beat && w_final_line;
    assign m_axis.aclk_tuser[2] = w_valid && w_first_beat && (r_line != 16'd0);
    assign m_axis.aclk_tuser[3] = w_valid && w_last_beat && !w_final_line;

    assign aclk_busy       = (r_state != IDLE);
    assign aclk_frame_done = r_frame_done;

endmodule
